// File: rtl/input_conditioner.sv
// input_conditioner: 2-flop sync + per-bit debounce of key_pin/sw_pin -> keys_export/sw_export, plus key_press/key_release pulses
module input_conditioner #(
    parameter int NKEYS           = 4,
    parameter int NSW             = 10,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic             clk_clk,
    input  logic             reset_reset,
    input  logic [NKEYS-1:0] key_pin,
    input  logic [NSW-1:0]   sw_pin,
    output logic [NKEYS-1:0] keys_export,
    output logic [NSW-1:0]   sw_export,
    output logic [NKEYS-1:0] key_press,
    output logic [NKEYS-1:0] key_release
);
    localparam int N = NKEYS + NSW;
    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [N-1:0] RST = {{NSW{1'b0}}, {NKEYS{1'b1}}};
    logic [N-1:0] s1, s2, stable, done;
    logic [CW-1:0] cnt [N];
    always_comb begin
        done = '0;
        for (int j = 0; j < N; j++) done[j] = (s2[j] != stable[j]) && (cnt[j] == CMAX);
    end
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            s1          <= RST;
            s2          <= RST;
            stable      <= RST;
            key_press   <= '0;
            key_release <= '0;
            for (int j = 0; j < N; j++) cnt[j] <= '0;
        end else begin
            s1          <= {sw_pin, key_pin};
            s2          <= s1;
            stable      <= stable ^ done;
            key_press   <= done[NKEYS-1:0] & stable[NKEYS-1:0];
            key_release <= done[NKEYS-1:0] & ~stable[NKEYS-1:0];
            for (int j = 0; j < N; j++) cnt[j] <= (s2[j] == stable[j] || done[j]) ? '0 : cnt[j] + 1'b1;
        end
    end
    assign keys_export = stable[NKEYS-1:0];
    assign sw_export   = stable[N-1:NKEYS];
endmodule
